// File: rtl/led_pattern_timer.sv
// Multi-channel LED driver: shared tick prescaler plus per-channel OFF/ON/BLINK/ONESHOT engines.
// Channels are reprogrammed through a single-cycle write port; all outputs are registered.
module led_pattern_timer #(
    parameter int CHANNELS   = 4,
    parameter int CLOCK_FREQ = 50_000_000,
    parameter int TICK_FREQ  = 1000,
    parameter int PERIOD_W   = 10,
    parameter int CH_W       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                wr_en,
    input  logic [CH_W-1:0]     wr_ch,
    input  logic [1:0]          wr_mode,
    input  logic [PERIOD_W-1:0] wr_period,
    output logic                tick,
    output logic [CHANNELS-1:0] led,
    output logic [CHANNELS-1:0] done
);

    localparam int TICK_DIV = CLOCK_FREQ / TICK_FREQ;
    localparam int PRE_W    = $clog2(TICK_DIV) + 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        MODE_OFF     = 2'd0,
        MODE_ON      = 2'd1,
        MODE_BLINK   = 2'd2,
        MODE_ONESHOT = 2'd3
    } mode_e;

    logic [PRE_W-1:0]    pre_cnt_r;
    logic [PRE_W-1:0]    pre_next_s;
    logic                tick_r;

    mode_e               mode_r   [CHANNELS];
    logic [PERIOD_W-1:0] period_r [CHANNELS];
    logic [PERIOD_W-1:0] cnt_r    [CHANNELS];
    logic [CHANNELS-1:0] led_r;
    logic [CHANNELS-1:0] done_r;

    mode_e               mode_s   [CHANNELS];
    logic [PERIOD_W-1:0] period_s [CHANNELS];
    logic [PERIOD_W-1:0] cnt_s    [CHANNELS];
    logic [CHANNELS-1:0] led_s;
    logic [CHANNELS-1:0] done_s;
    logic [CHANNELS-1:0] wr_hit_s;

    // Next prescaler count, wrapping at the last count of the divide ratio.
    always_comb begin
        if (pre_cnt_r == PRE_LAST) begin
            pre_next_s = {PRE_W{1'b0}};
        end else begin
            pre_next_s = pre_cnt_r + PRE_W'(1);
        end
    end

    // Free-running prescaler; tick is registered so it is high while the count sits at its last value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_cnt_r <= {PRE_W{1'b0}};
            tick_r    <= 1'b0;
        end else begin
            pre_cnt_r <= pre_next_s;
            tick_r    <= (pre_next_s == PRE_LAST);
        end
    end

    // Write decode; out-of-range channel indices match no channel and are dropped.
    always_comb begin
        wr_hit_s = {CHANNELS{1'b0}};
        for (int i = 0; i < CHANNELS; i++) begin
            wr_hit_s[i] = wr_en && (wr_ch == CH_W'(i));
        end
    end

    // Per-channel next state: a write takes priority over tick processing on the same channel.
    always_comb begin
        led_s  = led_r;
        done_s = {CHANNELS{1'b0}};
        for (int i = 0; i < CHANNELS; i++) begin
            mode_s[i]   = mode_r[i];
            period_s[i] = period_r[i];
            cnt_s[i]    = cnt_r[i];
            if (wr_hit_s[i]) begin
                mode_s[i]   = mode_e'(wr_mode);
                period_s[i] = wr_period;
                cnt_s[i]    = {PERIOD_W{1'b0}};
                led_s[i]    = (wr_mode != 2'd0);
            end else if (tick_r) begin
                case (mode_r[i])
                    MODE_OFF: begin
                        led_s[i] = 1'b0;
                    end
                    MODE_ON: begin
                        led_s[i] = 1'b1;
                    end
                    MODE_BLINK: begin
                        if (cnt_r[i] == period_r[i]) begin
                            cnt_s[i] = {PERIOD_W{1'b0}};
                            led_s[i] = ~led_r[i];
                        end else begin
                            cnt_s[i] = cnt_r[i] + PERIOD_W'(1);
                        end
                    end
                    MODE_ONESHOT: begin
                        // Expiry retires the channel to OFF so later ticks leave it dark.
                        if (cnt_r[i] == period_r[i]) begin
                            cnt_s[i]  = {PERIOD_W{1'b0}};
                            led_s[i]  = 1'b0;
                            mode_s[i] = MODE_OFF;
                            done_s[i] = 1'b1;
                        end else begin
                            cnt_s[i] = cnt_r[i] + PERIOD_W'(1);
                        end
                    end
                    default: begin
                        mode_s[i] = MODE_OFF;
                        led_s[i]  = 1'b0;
                    end
                endcase
            end else begin
                cnt_s[i] = cnt_r[i];
            end
        end
    end

    // Channel state and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < CHANNELS; i++) begin
                mode_r[i]   <= MODE_OFF;
                period_r[i] <= {PERIOD_W{1'b0}};
                cnt_r[i]    <= {PERIOD_W{1'b0}};
            end
            led_r  <= {CHANNELS{1'b0}};
            done_r <= {CHANNELS{1'b0}};
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                mode_r[i]   <= mode_s[i];
                period_r[i] <= period_s[i];
                cnt_r[i]    <= cnt_s[i];
            end
            led_r  <= led_s;
            done_r <= done_s;
        end
    end

    assign tick = tick_r;
    assign led  = led_r;
    assign done = done_r;

endmodule

// File: tb/tb_led_pattern_timer.sv
// Scoreboard bench for led_pattern_timer: stimulus queues expected led/done values per cycle,
// a negedge monitor pops and compares them. A 3-channel instance covers out-of-range writes.
module tb_led_pattern_timer;

    localparam int PW = 10;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          wr_en = 1'b0;
    logic [1:0]    wr_ch = 2'd0;
    logic [1:0]    wr_mode = 2'd0;
    logic [PW-1:0] wr_period = '0;
    logic          tick;
    logic [3:0]    led, done;

    logic          wr3_en = 1'b0;
    logic [1:0]    wr3_ch = 2'd0;
    logic [1:0]    wr3_mode = 2'd0;
    logic [PW-1:0] wr3_period = '0;
    logic          tick3;
    logic [2:0]    led3, done3;

    always #5 clk = ~clk;

    led_pattern_timer #(.CHANNELS(4), .CLOCK_FREQ(100), .TICK_FREQ(10), .PERIOD_W(PW)) u_dut (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_ch(wr_ch), .wr_mode(wr_mode),
        .wr_period(wr_period), .tick(tick), .led(led), .done(done)
    );

    led_pattern_timer #(.CHANNELS(3), .CLOCK_FREQ(100), .TICK_FREQ(10), .PERIOD_W(PW)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .wr_en(wr3_en), .wr_ch(wr3_ch), .wr_mode(wr3_mode),
        .wr_period(wr3_period), .tick(tick3), .led(led3), .done(done3)
    );

    typedef struct {
        int       cyc;
        bit       sel;
        logic [3:0] lm;
        logic [3:0] lv;
        logic [3:0] dm;
        logic [3:0] dv;
        string    name;
    } exp_t;

    exp_t q[$];
    int   ncyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    logic [3:0] mon_led, mon_done;

    always @(posedge clk) ncyc <= ncyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, ncyc);
        end
    endtask

    task automatic expect_at(input int cyc, input bit sel, input logic [3:0] lm, input logic [3:0] lv,
                             input logic [3:0] dm, input logic [3:0] dv, input string name);
        exp_t e;
        e.cyc = cyc; e.sel = sel; e.lm = lm; e.lv = lv; e.dm = dm; e.dv = dv; e.name = name;
        q.push_back(e);
    endtask

    // Monitor: compare every queued expectation due in the current cycle.
    always @(negedge clk) begin
        for (int i = q.size() - 1; i >= 0; i--) begin
            if (q[i].cyc == ncyc) begin
                mon_led  = q[i].sel ? {1'b0, led3}  : led;
                mon_done = q[i].sel ? {1'b0, done3} : done;
                check({q[i].name, "_led"},  mon_led  & q[i].lm, q[i].lv & q[i].lm);
                check({q[i].name, "_done"}, mon_done & q[i].dm, q[i].dv & q[i].dm);
                q.delete(i);
            end else if (q[i].cyc < ncyc) begin
                n_checks++;
                n_fail++;
                $display("FAIL %s: expectation for cycle %0d never compared", q[i].name, q[i].cyc);
                q.delete(i);
            end
        end
    end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic sync_tick(output int tc);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (tick !== 1'b1 && n < 30);
        if (tick !== 1'b1) begin
            n_checks++;
            n_fail++;
            $display("FAIL sync_tick: no tick within 30 cycles, got 0 expected 1");
        end
        tc = ncyc;
    endtask

    task automatic write(input logic [1:0] ch, input logic [1:0] mode, input int per);
        wr_en = 1'b1; wr_ch = ch; wr_mode = mode; wr_period = PW'(per);
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic wait_empty();
        int n;
        n = 0;
        while (q.size() != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL wait_empty: %0d expectations left, expected 0", q.size());
            q.delete();
        end
    endtask

    task automatic check_tick_timing(input string tag);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (tick !== 1'b1 && n < 30);
        check({tag, "_first_tick"}, n, 9);
        @(negedge clk);
        check({tag, "_tick_width"}, tick, 0);
        n = 1;
        while (tick !== 1'b1 && n < 30) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_tick_period"}, n, 10);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_led"},   led,   4'b0000);
        check({tag, "_done"},  done,  4'b0000);
        check({tag, "_tick"},  tick,  1'b0);
        check({tag, "_led3"},  led3,  3'b000);
        check({tag, "_done3"}, done3, 3'b000);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int tc, tc2, tc3, tc4, tc5, tc6, c;

        // Reset state and post-release prescaler timing
        #23;
        check_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;
        check_tick_timing("rel1");

        // BLINK ch0 period=2: toggles every third tick
        sync_tick(tc);
        expect_at(tc + 1,  1'b0, 4'b0001, 4'b0000, 4'b1111, 4'b0000, "s2_pre");
        expect_at(tc + 2,  1'b0, 4'b1111, 4'b0001, 4'b1111, 4'b0000, "s2_on");
        expect_at(tc + 30, 1'b0, 4'b0001, 4'b0001, 4'b0001, 4'b0000, "s2_hold");
        expect_at(tc + 31, 1'b0, 4'b1101, 4'b0000, 4'b0001, 4'b0000, "s2_toggle0");
        expect_at(tc + 60, 1'b0, 4'b0001, 4'b0000, 4'b0001, 4'b0000, "s2_hold0");
        expect_at(tc + 61, 1'b0, 4'b0001, 4'b0001, 4'b0001, 4'b0000, "s2_toggle1");
        step();
        write(2'd0, 2'd2, 2);

        // ONESHOT ch1 period=4: falls with done on the 5th tick
        sync_tick(tc2);
        check("s3_tick_spacing", tc2 - tc, 10);
        expect_at(tc2 + 1,  1'b0, 4'b0010, 4'b0000, 4'b1111, 4'b0000, "s3_pre");
        expect_at(tc2 + 2,  1'b0, 4'b0010, 4'b0010, 4'b1111, 4'b0000, "s3_on");
        expect_at(tc2 + 50, 1'b0, 4'b0010, 4'b0010, 4'b1111, 4'b0000, "s3_last_on");
        expect_at(tc2 + 51, 1'b0, 4'b0010, 4'b0000, 4'b1111, 4'b0010, "s3_fall");
        expect_at(tc2 + 52, 1'b0, 4'b0010, 4'b0000, 4'b1111, 4'b0000, "s3_done_clr");
        expect_at(tc2 + 61, 1'b0, 4'b0010, 4'b0000, 4'b1111, 4'b0000, "s3_stay_off");
        step();
        write(2'd1, 2'd3, 4);
        wait_empty();

        // Collision: ch0 rewritten on a tick cycle while ch2 blinks at period 0
        sync_tick(tc3);
        expect_at(tc3 + 2,  1'b0, 4'b0100, 4'b0100, 4'b1111, 4'b0000, "s4_ch2_on");
        expect_at(tc3 + 10, 1'b0, 4'b0100, 4'b0100, 4'b1111, 4'b0000, "s4_ch2_pre");
        expect_at(tc3 + 11, 1'b0, 4'b0101, 4'b0001, 4'b1111, 4'b0000, "s4_collide");
        expect_at(tc3 + 21, 1'b0, 4'b0101, 4'b0101, 4'b1111, 4'b0000, "s4_no_toggle");
        expect_at(tc3 + 25, 1'b0, 4'b1010, 4'b0000, 4'b1111, 4'b0000, "s4_idle");
        expect_at(tc3 + 30, 1'b0, 4'b0001, 4'b0001, 4'b1111, 4'b0000, "s4_ch0_hold");
        expect_at(tc3 + 31, 1'b0, 4'b0001, 4'b0000, 4'b1111, 4'b0000, "s4_ch0_tog0");
        expect_at(tc3 + 51, 1'b0, 4'b0001, 4'b0001, 4'b1111, 4'b0000, "s4_ch0_tog1");
        step();
        write(2'd2, 2'd2, 0);
        sync_tick(tc4);
        check("s4_tick_spacing", tc4 - tc3, 10);
        write(2'd0, 2'd2, 1);
        wait_empty();

        // Invalid channel on the 3-channel instance; ONESHOT overwritten with ON
        sync_tick(tc5);
        expect_at(tc5 + 1,  1'b1, 4'b0111, 4'b0000, 4'b0111, 4'b0000, "s5_inv_pre");
        expect_at(tc5 + 2,  1'b1, 4'b0111, 4'b0010, 4'b0111, 4'b0000, "s5_inv_ch1");
        expect_at(tc5 + 3,  1'b1, 4'b0111, 4'b0010, 4'b0111, 4'b0000, "s5_inv_on");
        expect_at(tc5 + 4,  1'b1, 4'b0111, 4'b0010, 4'b0111, 4'b0000, "s5_inv_off");
        expect_at(tc5 + 30, 1'b1, 4'b0111, 4'b0010, 4'b0111, 4'b0000, "s5_inv_late");
        expect_at(tc5 + 2,  1'b0, 4'b0010, 4'b0010, 4'b0010, 4'b0000, "s5_os_on");
        expect_at(tc5 + 21, 1'b0, 4'b0010, 4'b0010, 4'b0010, 4'b0000, "s5_os_mid");
        expect_at(tc5 + 22, 1'b0, 4'b0010, 4'b0010, 4'b0010, 4'b0000, "s5_ow_on");
        expect_at(tc5 + 41, 1'b0, 4'b0010, 4'b0010, 4'b0010, 4'b0000, "s5_ow_nofall");
        expect_at(tc5 + 42, 1'b0, 4'b0010, 4'b0010, 4'b0010, 4'b0000, "s5_ow_nodone");
        expect_at(tc5 + 51, 1'b0, 4'b0010, 4'b0010, 4'b0010, 4'b0000, "s5_ow_late");
        step();
        wr3_en = 1'b1; wr3_ch = 2'd1; wr3_mode = 2'd1; wr3_period = '0;
        write(2'd1, 2'd3, 3);
        wr3_ch = 2'd3; wr3_mode = 2'd1;
        step();
        wr3_ch = 2'd3; wr3_mode = 2'd0;
        step();
        wr3_en = 1'b0;
        while (ncyc < tc5 + 21) step();
        write(2'd1, 2'd1, 0);
        wait_empty();

        // Async reset mid-cycle during active BLINK/ONESHOT, then idle after release
        sync_tick(tc6);
        expect_at(tc6 + 2, 1'b0, 4'b1000, 4'b1000, 4'b1111, 4'b0000, "s6_os_on");
        step();
        write(2'd3, 2'd3, 5);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("s6_async");
        repeat (3) @(negedge clk);
        check_all_zero("s6_held");
        rst_n = 1'b1;
        check_tick_timing("rel2");
        c = ncyc;
        expect_at(c + 5,  1'b0, 4'b1111, 4'b0000, 4'b1111, 4'b0000, "s6_idle_a");
        expect_at(c + 15, 1'b0, 4'b1111, 4'b0000, 4'b1111, 4'b0000, "s6_idle_b");
        expect_at(c + 35, 1'b0, 4'b1111, 4'b0000, 4'b1111, 4'b0000, "s6_idle_c");
        expect_at(c + 15, 1'b1, 4'b0111, 4'b0000, 4'b0111, 4'b0000, "s6_idle3");
        wait_empty();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
